// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer_if
// Brief    : Request/result bundle between the execute stage and the divider.
// Revision : 1.0
// ============================================================================
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             stall;

    // Execute stage side: issues divides, consumes results and stall.
    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, stall
    );

    // Divider side.
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, stall
    );
endinterface
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Brief    : Radix-2 restoring divider for UDIV/SDIV, one quotient bit/cycle.
// Revision : 1.0
// ============================================================================
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        c_IDLE = 3'd0,
        c_PREP = 3'd1,
        c_ITER = 3'd2,
        c_FIX  = 3'd3,
        c_DONE = 3'd4
    } divState_e;

    divState_e        r_state;
    logic [CW-1:0]    r_count;
    logic             r_isSigned;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_magDividend;
    logic [WIDTH-1:0] r_magDivisor;
    logic [WIDTH-1:0] r_partRem;
    logic             r_negQ;
    logic             r_negR;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_trial;
    logic             w_divNeg;
    logic             w_dsrNeg;

    // Shifted partial remainder can exceed WIDTH bits, so the trial is WIDTH+1.
    assign w_remShift = {r_partRem, r_magDividend[WIDTH-1]};
    assign w_trial    = w_remShift - {1'b0, r_magDivisor};
    assign w_divNeg   = r_isSigned & r_dividend[WIDTH-1];
    assign w_dsrNeg   = r_isSigned & r_divisor[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_isSigned    <= 1'b0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_magDividend <= '0;
            r_magDivisor  <= '0;
            r_partRem     <= '0;
            r_negQ        <= 1'b0;
            r_negR        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
        end else if (bus.flush) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                        r_isSigned <= bus.is_signed;
                        r_busy     <= 1'b1;
                        r_state    <= c_PREP;
                    end
                end
                c_PREP: begin
                    r_magDividend <= w_divNeg ? -r_dividend : r_dividend;
                    r_magDivisor  <= w_dsrNeg ? -r_divisor : r_divisor;
                    r_negQ        <= w_divNeg ^ w_dsrNeg;
                    r_negR        <= w_divNeg;
                    r_partRem     <= '0;
                    r_count       <= '0;
                    if (r_divisor == '0) begin
                        r_quotient  <= '0;
                        r_remainder <= r_dividend;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_state <= c_ITER;
                    end
                end
                c_ITER: begin
                    // Quotient bits shift into the vacated low end of the dividend.
                    r_magDividend <= {r_magDividend[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_partRem     <= w_trial[WIDTH] ? w_remShift[WIDTH-1:0]
                                                    : w_trial[WIDTH-1:0];
                    if (r_count == c_LAST_COUNT) begin
                        r_count <= '0;
                        r_state <= c_FIX;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                c_FIX: begin
                    r_quotient  <= r_negQ ? -r_magDividend : r_magDividend;
                    r_remainder <= r_negR ? -r_partRem : r_partRem;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    // Stall must cover the issue cycle itself, before busy has risen.
    assign bus.stall     = (bus.start & (r_state == c_IDLE)) | r_busy;
endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sequencer
// Brief    : Directed self-checking bench for div_sequencer (WIDTH = 32).
// Revision : 1.0
// ============================================================================
module tb_div_sequencer;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   errCount;
    int   checkCount;

    div_sequencer_if #(.WIDTH(WIDTH)) divBus ();

    div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (divBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // expLat counts edges after the sampling edge until done is visible.
    task automatic runDiv(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expQ,
                          input logic [31:0] expR, input int expLat, input bit intrude);
        int lat;
        bit stallOk;
        @(negedge clk);
        divBus.start     = 1'b1;
        divBus.is_signed = sg;
        divBus.dividend  = a;
        divBus.divisor   = b;
        #1 stallOk = (divBus.stall === 1'b1);
        @(posedge clk);
        #1 divBus.start = 1'b0;
        lat = 0;
        while (divBus.done !== 1'b1 && lat < 100) begin
            if (divBus.stall !== 1'b1) stallOk = 1'b0;
            if (intrude && lat == 3) begin
                divBus.start     = 1'b1;
                divBus.is_signed = 1'b0;
                divBus.dividend  = 32'd50;
                divBus.divisor   = 32'd5;
            end else begin
                divBus.start = 1'b0;
            end
            @(posedge clk);
            #1 lat++;
        end
        divBus.start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        check({tag, ".quotient"}, divBus.quotient, expQ);
        check({tag, ".remainder"}, divBus.remainder, expR);
        check({tag, ".stallHeld"}, {31'd0, stallOk}, 32'd1);
        check({tag, ".stallAtDone"}, {31'd0, divBus.stall}, 32'd0);
        check({tag, ".busyAtDone"}, {31'd0, divBus.busy}, 32'd0);
        @(posedge clk);
        #1 check({tag, ".donePulse"}, {31'd0, divBus.done}, 32'd0);
    endtask

    initial begin
        bit sawDone;
        errCount         = 0;
        checkCount       = 0;
        reset            = 1'b0;
        divBus.start     = 1'b0;
        divBus.is_signed = 1'b0;
        divBus.dividend  = '0;
        divBus.divisor   = '0;
        divBus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {31'd0, divBus.busy}, 32'd0);
        check("rst.done", {31'd0, divBus.done}, 32'd0);
        check("rst.quotient", divBus.quotient, 32'd0);
        check("rst.remainder", divBus.remainder, 32'd0);
        check("rst.stall", {31'd0, divBus.stall}, 32'd0);
        @(negedge clk) reset = 1'b1;

        runDiv("udiv100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);
        runDiv("sdivM7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0);
        runDiv("sdiv7_M2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 1'b0);
        runDiv("sdivZero", 1'b1, 32'h1234, 32'd0, 32'd0, 32'h1234, 1, 1'b0);
        runDiv("udivZero", 1'b0, 32'h1234, 32'd0, 32'd0, 32'h1234, 1, 1'b0);
        runDiv("sdivOvf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 1'b0);
        runDiv("udivMax", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);

        // Flush while ITER holds count 10 (11 edges after the sampling edge).
        @(negedge clk);
        divBus.start     = 1'b1;
        divBus.is_signed = 1'b0;
        divBus.dividend  = 32'd1000;
        divBus.divisor   = 32'd3;
        @(posedge clk);
        #1 divBus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 divBus.flush = 1'b1;
        @(posedge clk);
        #1 divBus.flush = 1'b0;
        check("flush.busy", {31'd0, divBus.busy}, 32'd0);
        check("flush.stall", {31'd0, divBus.stall}, 32'd0);
        check("flush.quotientKept", divBus.quotient, 32'hFFFF_FFFF);
        sawDone = 1'b0;
        repeat (40) begin
            if (divBus.done === 1'b1) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush.noDone", {31'd0, sawDone}, 32'd0);
        runDiv("afterFlush", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);

        // Asynchronous reset between edges in the middle of ITER.
        @(negedge clk);
        divBus.start     = 1'b1;
        divBus.dividend  = 32'd1000;
        divBus.divisor   = 32'd3;
        @(posedge clk);
        #1 divBus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst.busy", {31'd0, divBus.busy}, 32'd0);
        check("arst.quotient", divBus.quotient, 32'd0);
        check("arst.remainder", divBus.remainder, 32'd0);
        check("arst.stall", {31'd0, divBus.stall}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // start and flush together in IDLE: nothing is launched.
        @(negedge clk);
        divBus.start    = 1'b1;
        divBus.flush    = 1'b1;
        divBus.dividend = 32'd9;
        divBus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        divBus.start = 1'b0;
        divBus.flush = 1'b0;
        check("startFlush.busy", {31'd0, divBus.busy}, 32'd0);
        sawDone = 1'b0;
        repeat (5) begin
            if (divBus.done === 1'b1) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        check("startFlush.noDone", {31'd0, sawDone}, 32'd0);

        // A start pulsed while busy must not disturb the running divide.
        runDiv("intrude", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b1);
        check("intrude.idleAfter", {31'd0, divBus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
`default_nettype wire
